// File: rtl/pipe_run_ctrl_if.sv
// Debug command channel for the pipeline run controller.
// The debugger side (master) presents a command; the controller (slave)
// consumes it in the same cycle and may flag it as illegal one cycle later.
interface pipe_run_ctrl_if;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        cmd_ready;
  logic        cmd_err;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready,
    input  cmd_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready,
    output cmd_err
  );
endinterface

// File: rtl/pipe_run_ctrl.sv
// Run/halt/step debug controller for the 5-stage pipelined CPU.
// Watches retirements in WB and drives a single global stall that freezes the
// PC and every pipeline register. Supports a retirement PC breakpoint,
// N-instruction stepping, and free-running cycle/retire counters.
module pipe_run_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CNT_W        = 32,
  parameter bit          RESET_HALTED = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,        // active-high asynchronous reset
  pipe_run_ctrl_if.slave   cmd,
  input  logic             bp_en,
  input  logic [XLEN-1:0]  bp_addr,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  pc_WB,
  output logic             stall_o,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } state_e;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_HALT  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_CMD  = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_STEP = 2'd3;

  localparam state_e RST_STATE = RESET_HALTED ? ST_HALTED : ST_RUNNING;

  state_e           state_q, state_d;
  logic [15:0]      step_rem_q, step_rem_d;
  logic [1:0]       cause_q, cause_d;
  logic             cmd_err_q, cmd_err_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  logic stalled;
  logic ret;
  logic hit;
  logic cmd_run, cmd_halt, cmd_step, cmd_clear;

  // The stall is a pure function of the registered state, so it is glitch-free
  // and takes effect exactly one edge after the deciding event.
  assign stalled = (state_q == ST_HALTED);

  // A frozen WB instruction is not a retirement; this also keeps a breakpoint
  // from re-firing while parked on it.
  assign ret = wb_valid & ~stalled;
  assign hit = ret & bp_en & (pc_WB == bp_addr);

  assign cmd_run   = cmd.cmd_valid & (cmd.cmd_op == OP_RUN);
  assign cmd_halt  = cmd.cmd_valid & (cmd.cmd_op == OP_HALT);
  assign cmd_step  = cmd.cmd_valid & (cmd.cmd_op == OP_STEP);
  assign cmd_clear = cmd.cmd_valid & (cmd.cmd_op == OP_CLEAR);

  // Next-state: command handling, halt arbitration (bp > step done > HALT cmd)
  // and counter updates.
  always_comb begin
    state_d    = state_q;
    step_rem_d = step_rem_q;
    cause_d    = cause_q;
    cmd_err_d  = 1'b0;
    cycle_d    = cycle_q;
    retire_d   = retire_q;

    if (!stalled) begin
      cycle_d = cycle_q + 1'b1;
    end
    if (ret) begin
      retire_d = retire_q + 1'b1;
    end

    // Only HALT is legal outside HALTED; everything else is dropped and flagged.
    if (cmd.cmd_valid && (cmd.cmd_op != OP_HALT) && (state_q != ST_HALTED)) begin
      cmd_err_d = 1'b1;
    end

    case (state_q)
      ST_HALTED: begin
        if (cmd_run) begin
          state_d = ST_RUNNING;
        end else if (cmd_step) begin
          state_d    = ST_STEPPING;
          step_rem_d = (cmd.cmd_arg == 16'd0) ? 16'd1 : cmd.cmd_arg;
        end else if (cmd_clear) begin
          cycle_d  = '0;
          retire_d = '0;
        end
      end

      ST_RUNNING: begin
        if (hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end else if (cmd_halt) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_CMD;
        end
      end

      ST_STEPPING: begin
        if (hit) begin
          state_d    = ST_HALTED;
          cause_d    = CAUSE_BP;
          step_rem_d = 16'd0;
        end else if (ret && (step_rem_q == 16'd1)) begin
          state_d    = ST_HALTED;
          cause_d    = CAUSE_STEP;
          step_rem_d = 16'd0;
        end else if (cmd_halt) begin
          state_d    = ST_HALTED;
          cause_d    = CAUSE_CMD;
          step_rem_d = 16'd0;
        end else if (ret) begin
          step_rem_d = step_rem_q - 16'd1;
        end
      end

      default: begin
        state_d    = RST_STATE;
        step_rem_d = 16'd0;
      end
    endcase
  end

  // State and counter registers; reset discards any run or step in progress.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= RST_STATE;
      step_rem_q <= 16'd0;
      cause_q    <= CAUSE_NONE;
      cmd_err_q  <= 1'b0;
      cycle_q    <= '0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      step_rem_q <= step_rem_d;
      cause_q    <= cause_d;
      cmd_err_q  <= cmd_err_d;
      cycle_q    <= cycle_d;
      retire_q   <= retire_d;
    end
  end

  assign stall_o       = stalled;
  assign halted        = stalled;
  assign halt_cause    = cause_q;
  assign cycle_cnt     = cycle_q;
  assign retire_cnt    = retire_q;
  assign cmd.cmd_ready = 1'b1;
  assign cmd.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Scoreboard bench for pipe_run_ctrl: each driven cycle pushes the expected
// post-edge outputs, which a checker pops and compares just after the edge.
module tb_pipe_run_ctrl;

  logic        clk;
  logic        rstn;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic        wb_valid;
  logic [31:0] pc_WB;
  logic        stall_o;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;

  pipe_run_ctrl_if cmd_if ();

  pipe_run_ctrl #(
    .XLEN(32),
    .CNT_W(32),
    .RESET_HALTED(1'b0)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd        (cmd_if),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .wb_valid   (wb_valid),
    .pc_WB      (pc_WB),
    .stall_o    (stall_o),
    .halted     (halted),
    .halt_cause (halt_cause),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        stall;
    logic [1:0]  cause;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Expected counter values, advanced from the stall level the bench expects
  // to be in force during each driven cycle.
  logic        m_stall = 1'b0;
  logic [31:0] m_cyc   = '0;
  logic [31:0] m_ret   = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus (caller sits at a falling edge) and queue the
  // outputs expected after the next rising edge.
  task automatic drive(input string tag, input logic v, input logic [1:0] op,
                       input logic [15:0] arg, input logic wbv, input logic [31:0] pc,
                       input logic e_stall, input logic [1:0] e_cause, input logic e_err);
    exp_t e;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    wb_valid         = wbv;
    pc_WB            = pc;
    if (!m_stall) begin
      m_cyc = m_cyc + 1;
      if (wbv) m_ret = m_ret + 1;
    end else if (v && op == 2'b11) begin
      m_cyc = '0;
      m_ret = '0;
    end
    m_stall = e_stall;
    e.tag   = tag;
    e.stall = e_stall;
    e.cause = e_cause;
    e.cyc   = m_cyc;
    e.ret   = m_ret;
    e.err   = e_err;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Checker: compare one queued expectation just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val({e.tag, ".stall"},  stall_o,          e.stall);
        check_val({e.tag, ".halted"}, halted,           e.stall);
        check_val({e.tag, ".cause"},  halt_cause,       e.cause);
        check_val({e.tag, ".cyc"},    cycle_cnt,        e.cyc);
        check_val({e.tag, ".ret"},    retire_cnt,       e.ret);
        check_val({e.tag, ".err"},    cmd_if.cmd_err,   e.err);
        check_val({e.tag, ".ready"},  cmd_if.cmd_ready, 1'b1);
        $display("txn %-12s stall=%0b cause=%0d cyc=%0d ret=%0d err=%0b",
                 e.tag, stall_o, halt_cause, cycle_cnt, retire_cnt, cmd_if.cmd_err);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn             = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_arg   = 16'd0;
    bp_en            = 1'b0;
    bp_addr          = 32'h0;
    wb_valid         = 1'b0;
    pc_WB            = 32'h0;

    // Reset values
    #2 rstn = 1'b1;
    #1;
    check_val("rst.stall", stall_o, 1'b0);
    check_val("rst.cause", halt_cause, 2'd0);
    check_val("rst.cyc", cycle_cnt, 32'd0);
    check_val("rst.ret", retire_cnt, 32'd0);
    check_val("rst.err", cmd_if.cmd_err, 1'b0);
    @(negedge clk);
    rstn = 1'b0;

    // 1: free run, 10 retirements
    for (int i = 0; i < 10; i++)
      drive("run", 1'b0, 2'b00, 16'd0, 1'b1, 32'(i * 4), 1'b0, 2'd0, 1'b0);
    check_val("t1.cyc", cycle_cnt, 32'd10);
    check_val("t1.ret", retire_cnt, 32'd10);

    // 2: breakpoint at 0x78, then 20 frozen cycles parked on it
    bp_en   = 1'b1;
    bp_addr = 32'h78;
    for (int i = 0; i < 14; i++)
      drive("bp_pre", 1'b0, 2'b00, 16'd0, 1'b1, 32'h40 + 32'(i * 4), 1'b0, 2'd0, 1'b0);
    drive("bp_hit", 1'b0, 2'b00, 16'd0, 1'b1, 32'h78, 1'b1, 2'd2, 1'b0);
    check_val("t2.ret", retire_cnt, 32'd25);
    for (int i = 0; i < 20; i++)
      drive("bp_frozen", 1'b0, 2'b00, 16'd0, 1'b1, 32'h78, 1'b1, 2'd2, 1'b0);
    check_val("t2.cyc_frozen", cycle_cnt, 32'd25);
    check_val("t2.ret_frozen", retire_cnt, 32'd25);
    drive("halt_in_halt", 1'b1, 2'b01, 16'd0, 1'b0, 32'h78, 1'b1, 2'd2, 1'b0);

    // 3: STEP 3 with retirements on cycles 1, 2, 4; CLEAR mid-step is rejected
    drive("step3", 1'b1, 2'b10, 16'd3, 1'b1, 32'h78, 1'b0, 2'd2, 1'b0);
    drive("step3_r1", 1'b0, 2'b00, 16'd0, 1'b1, 32'h7C, 1'b0, 2'd2, 1'b0);
    drive("step3_r2", 1'b0, 2'b00, 16'd0, 1'b1, 32'h80, 1'b0, 2'd2, 1'b0);
    drive("step3_clr", 1'b1, 2'b11, 16'd0, 1'b0, 32'h84, 1'b0, 2'd2, 1'b1);
    drive("step3_r3", 1'b0, 2'b00, 16'd0, 1'b1, 32'h84, 1'b1, 2'd3, 1'b0);
    check_val("t3.ret", retire_cnt, 32'd28);
    check_val("t3.cyc", cycle_cnt, 32'd29);
    drive("step3_idle", 1'b0, 2'b00, 16'd0, 1'b1, 32'h88, 1'b1, 2'd3, 1'b0);

    // 4: STEP 0 behaves as STEP 1
    drive("step0", 1'b1, 2'b10, 16'd0, 1'b0, 32'h88, 1'b0, 2'd3, 1'b0);
    drive("step0_gap", 1'b0, 2'b00, 16'd0, 1'b0, 32'h88, 1'b0, 2'd3, 1'b0);
    drive("step0_r1", 1'b0, 2'b00, 16'd0, 1'b1, 32'h88, 1'b1, 2'd3, 1'b0);
    check_val("t4.ret", retire_cnt, 32'd29);
    drive("step0_idle", 1'b0, 2'b00, 16'd0, 1'b1, 32'h8C, 1'b1, 2'd3, 1'b0);

    // 5: last step retirement coincides with bp hit and HALT -> bp wins
    drive("step1a", 1'b1, 2'b10, 16'd1, 1'b0, 32'h8C, 1'b0, 2'd3, 1'b0);
    drive("prio_bp", 1'b1, 2'b01, 16'd0, 1'b1, 32'h78, 1'b1, 2'd2, 1'b0);
    // step complete outranks a coincident HALT
    drive("step1b", 1'b1, 2'b10, 16'd1, 1'b0, 32'h8C, 1'b0, 2'd2, 1'b0);
    drive("prio_step", 1'b1, 2'b01, 16'd0, 1'b1, 32'h8C, 1'b1, 2'd3, 1'b0);

    // 6: RUN while RUNNING is rejected; HALT; CLEAR while HALTED
    drive("resume", 1'b1, 2'b00, 16'd0, 1'b0, 32'h90, 1'b0, 2'd3, 1'b0);
    drive("run_in_run", 1'b1, 2'b00, 16'd0, 1'b1, 32'h90, 1'b0, 2'd3, 1'b1);
    drive("err_clear", 1'b0, 2'b00, 16'd0, 1'b1, 32'h94, 1'b0, 2'd3, 1'b0);
    drive("halt_cmd", 1'b1, 2'b01, 16'd0, 1'b1, 32'h98, 1'b1, 2'd1, 1'b0);
    drive("clear", 1'b1, 2'b11, 16'd0, 1'b1, 32'h98, 1'b1, 2'd1, 1'b0);
    check_val("t6.cyc_clr", cycle_cnt, 32'd0);
    check_val("t6.ret_clr", retire_cnt, 32'd0);
    drive("step5", 1'b1, 2'b10, 16'd5, 1'b0, 32'h9C, 1'b0, 2'd1, 1'b0);
    drive("step5_r1", 1'b0, 2'b00, 16'd0, 1'b1, 32'h9C, 1'b0, 2'd1, 1'b0);

    // Asynchronous reset in the middle of a step
    #2 rstn = 1'b1;
    #1;
    check_val("midrst.stall", stall_o, 1'b0);
    check_val("midrst.cause", halt_cause, 2'd0);
    check_val("midrst.cyc", cycle_cnt, 32'd0);
    check_val("midrst.ret", retire_cnt, 32'd0);
    check_val("midrst.err", cmd_if.cmd_err, 1'b0);
    cmd_if.cmd_valid = 1'b0;
    wb_valid         = 1'b0;
    @(negedge clk);
    rstn    = 1'b0;
    m_stall = 1'b0;
    m_cyc   = '0;
    m_ret   = '0;
    for (int i = 0; i < 3; i++)
      drive("post_rst", 1'b0, 2'b00, 16'd0, 1'b1, 32'h200 + 32'(i * 4), 1'b0, 2'd0, 1'b0);
    drive("post_halt", 1'b1, 2'b01, 16'd0, 1'b0, 32'h20C, 1'b1, 2'd1, 1'b0);
    check_val("t6.cyc_post", cycle_cnt, 32'd4);
    check_val("t6.ret_post", retire_cnt, 32'd3);

    @(posedge clk);
    #2;
    check_val("sb.empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
Run/halt/step controller for the 5-stage pipelined CPU. It watches retirements in WB (pc_WB, wb_valid) and drives one global stall that freezes the PC and every pipeline register. It supports a PC breakpoint on retirement, N-instruction single-stepping, and cycle and retire counters. This replaces ad-hoc "stop at last instruction" checks with a synthesizable debug controller sitting beside the CPU top.

Parameters:
XLEN, 32, address width of pc_WB and bp_addr
CNT_W, 32, width of cycle_cnt and retire_cnt
RESET_HALTED, 0, 1 = come out of reset in HALTED; 0 = come out of reset in RUNNING

Ports:
clk  input  1  system clock; all state updates on rising edge
rstn  input  1  asynchronous, active-high reset (asserted = 1)
cmd_valid  input  1  command strobe
cmd_op  input  2  command: 00 RUN, 01 HALT, 10 STEP, 11 CLEAR
cmd_arg  input  16  STEP count (0 treated as 1); ignored for other ops
cmd_ready  output  1  constant 1; every command is consumed in the cycle it is presented
cmd_err  output  1  one-cycle pulse: command illegal in current state, dropped
bp_en  input  1  breakpoint enable
bp_addr  input  XLEN  breakpoint PC, compared against pc_WB
wb_valid  input  1  a valid instruction is in WB this cycle
pc_WB  input  XLEN  PC of the instruction in WB
stall_o  output  1  registered; 1 freezes the PC and all pipeline registers
halted  output  1  registered; 1 when state == HALTED (equals stall_o)
halt_cause  output  2  0 none/reset, 1 HALT command, 2 breakpoint, 3 step complete
cycle_cnt  output  CNT_W  count of unstalled cycles
retire_cnt  output  CNT_W  count of retired instructions

Behaviour:
- States: HALTED, RUNNING, STEPPING. Encoding is free. stall_o = halted = (state == HALTED), registered.
- Reset (rstn = 1, async):
  - state = HALTED if RESET_HALTED else RUNNING.
  - stall_o/halted follow the state.
  - halt_cause = 0, step_rem = 0, counters = 0, cmd_err = 0.
  - Reset mid-step or mid-run discards all progress.
- retire event: ret = wb_valid & ~stall_o.
- bp hit: hit = ret & bp_en & (pc_WB == bp_addr). The breakpoint instruction has retired when the halt takes effect.
- Transitions:
  - All commands and events are sampled at edge N; the new state and stall_o are visible after edge N, so latency is 1 cycle.
  - HALTED + RUN -> RUNNING.
  - HALTED + STEP -> STEPPING with step_rem = max(cmd_arg, 1).
  - HALTED + HALT -> stays HALTED, cause unchanged, no error.
  - HALTED + CLEAR -> cycle_cnt = retire_cnt = 0.
  - RUNNING + HALT -> HALTED, cause 1.
  - RUNNING + hit -> HALTED, cause 2.
  - STEPPING + ret -> step_rem decrements.
  - STEPPING, when ret occurs with step_rem == 1 -> HALTED, cause 3.
  - STEPPING + HALT -> HALTED, cause 1.
  - STEPPING + hit -> HALTED, cause 2.
  - RUN, STEP or CLEAR while not HALTED -> dropped, cmd_err pulses 1 cycle, no state change.
- Priority when events coincide at the same edge: hit (2) > step complete (3) > HALT command (1). Exactly one cause is latched.
- halt_cause holds its value until the next halt. It is not cleared by RUN or STEP.
- Resuming RUN from a breakpoint does not re-trigger, because the matching instruction has already left WB.
- Counters:
  - cycle_cnt increments every cycle with stall_o = 0.
  - retire_cnt increments on ret.
  - Both wrap modulo 2^CNT_W with no saturation.
  - The cycle in which a halt is decided still counts, since stall_o was 0 in that cycle.
- stall_o = 1 with wb_valid = 1 never counts as a retirement (the frozen WB instruction is not re-counted).

Test Plan:
1. RESET_HALTED=0, release reset, 10 cycles with wb_valid=1 -> stall_o=0, cycle_cnt=10, retire_cnt=10, halt_cause=0.
2. Breakpoint: bp_en=1, bp_addr=0x78, pc_WB reaches 0x78 with wb_valid=1 at edge N -> stall_o=1 after N, halt_cause=2. retire_cnt includes the 0x78 instruction, and both counters stay frozen over 20 further cycles.
3. STEP from HALTED with cmd_arg=3, retirements on cycles 1, 2, 4 after acceptance -> state STEPPING until the third retirement, then halted, halt_cause=3, retire_cnt += 3.
4. STEP with cmd_arg=0 -> exactly 1 retirement, then halted, cause 3.
5. In STEPPING with step_rem=1, ret coinciding with a bp hit and a HALT command -> halted, halt_cause=2, cmd_err=0.
6. RUN while RUNNING -> cmd_err one-cycle pulse, no state change. CLEAR while HALTED -> counters 0. Assert rstn mid-STEPPING -> immediate reset values, step_rem=0.
